ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  upstream request present.
REQ-006 req_ready  output  1  controller accepts request this cycle.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  request address.
REQ-009 req_wdata  input  DATA_W  write data.
REQ-010 rsp_valid  output  1  response held for upstream.
REQ-011 rsp_ready  input  1  upstream takes response.
REQ-012 rsp_data  output  DATA_W  read data (write data for write acks).
REQ-013 rsp_is_wr  output  1  response is a write ack.
REQ-014 ram_addr  output  ADDR_W  to RAM addr.
REQ-015 ram_wdata  output  DATA_W  to RAM data_in.
REQ-016 ram_we  output  1  to RAM write_en.
REQ-017 ram_rdata  input  DATA_W  from RAM data_out (registered read address, data valid the cycle after the address edge).
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 rd_cnt, wr_cnt  output  8 each  completed read and write counts.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, CAPTURE, and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted at an edge where req_valid && req_ready.
REQ-022 On accept, the block SHALL register req_addr/req_wdata into ram_addr/ram_wdata, set ram_we = req_write, and go to ISSUE.
REQ-023 ram_we SHALL be high only during the ISSUE cycle of a write, for exactly one cycle per accepted write.
REQ-024 ISSUE -> CAPTURE for reads; for writes, ISSUE -> IDLE (or RESP, see REQ-033), with wr_cnt += 1 at that edge.
REQ-025 In CAPTURE, rsp_data SHALL load ram_rdata at the edge, rd_cnt += 1, and the state SHALL go to RESP.
REQ-026 Read latency: accept at edge N, rsp_valid high from edge N+2.
REQ-027 RESP SHALL hold rsp_valid, rsp_data, and rsp_is_wr stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-028 rsp_valid SHALL be 0 in all states except RESP.
REQ-029 Requests presented outside IDLE SHALL be ignored; there is no queuing.
REQ-030 ram_addr/ram_wdata SHALL hold their last values while idle; wrap at 63 is natural (no special case).
REQ-031 rd_cnt/wr_cnt SHALL wrap from 255 to 0.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, ram_we 0, rsp_valid 0, rsp_is_wr 0, rsp_data 0, ram_addr 0, ram_wdata 0, rd_cnt 0, wr_cnt 0, busy 0. An in-flight operation SHALL be discarded; RAM contents are untouched; req_ready SHALL be 1 after the first edge with rst_n high.

Configuration
REQ-033 Macro RAM_CTRL_WRITE_ACK_EN:
- Defined: a write goes ISSUE -> RESP with rsp_is_wr = 1 and rsp_data = written data; it follows the RESP handshake (response at edge N+1).
- Undefined: a write returns to IDLE with no response; rsp_is_wr is tied 0.

Verification
REQ-034 After reset, write addr 5 data 101 -> one ram_we pulse with ram_addr 5 and ram_wdata 101; wr_cnt = 1; no rsp_valid (macro off).
REQ-035 Write addr 5 data 101, then read addr 5 -> rsp_valid at accept+2 edges, rsp_data 101, rsp_is_wr 0, rd_cnt = 1.
REQ-036 Read addr 63 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable; req_ready stays 0; IDLE one edge after rsp_ready goes to 1.
REQ-037 Assert rst_n low during ISSUE of a write to addr 7 -> ram_we drops immediately, counters 0, busy 0.
REQ-038 Macro on: write addr 2 data 111 -> rsp_valid at accept+1 edge, rsp_is_wr 1, rsp_data 111.
REQ-039 Issue 256 reads -> rd_cnt returns to 0.

Source files
------------

// File: rtl/ram_ctrl.sv
// ---------------------------------------------------------------------------
// ram_ctrl -- single-outstanding request controller in front of a synchronous
// RAM that has a registered read address (read data is valid the cycle after
// the address edge).
//
// Handshakes use valid/ready semantics on both sides. A transfer happens at a
// rising edge where valid && ready are both high. A producer holds valid and
// its payload stable until that edge.
//
// Ports
//   clk, rst_n              clock and asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write/addr/wdata    request payload (1 = write)
//   rsp_valid/rsp_ready     response handshake (valid only in RESP)
//   rsp_data, rsp_is_wr     response payload
//   ram_addr/wdata/we       to RAM
//   ram_rdata               from RAM
//   busy                    state is not IDLE
//   rd_cnt, wr_cnt          completed read / write counts (wrap at 255)
//   o_dbg_state             current FSM state, for checkers
//
// Configuration macro: RAM_CTRL_WRITE_ACK_EN
//   defined   : writes return a response (rsp_is_wr = 1, rsp_data = wdata)
//   undefined : writes complete silently, rsp_is_wr tied to 0
// ---------------------------------------------------------------------------
module ram_ctrl #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_is_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic [7:0]        rd_cnt,
   output logic [7:0]        wr_cnt,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_rdy_en;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_ram_we;
   logic [DATA_W-1:0] r_rsp_data;
   logic [7:0]        r_rd_cnt;
   logic [7:0]        r_wr_cnt;
   logic              w_accept;
   logic              w_ack_wr;

   // req_ready stays low while in reset and comes up after the first edge
   // with rst_n released.
   assign req_ready = (r_state == IDLE) && r_rdy_en;
   assign w_accept  = req_valid && req_ready;

`ifdef RAM_CTRL_WRITE_ACK_EN
   assign w_ack_wr = 1'b1;
`else
   assign w_ack_wr = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic. In ISSUE, r_ram_we is high exactly when the accepted
   // request was a write, so it doubles as the write/read flag.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = ISSUE;
         ISSUE: begin
            if (!r_ram_we)     w_next_state = CAPTURE;
            else if (w_ack_wr) w_next_state = RESP;
            else               w_next_state = IDLE;
         end
         CAPTURE: w_next_state = RESP;
         RESP:    if (rsp_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Datapath and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_ram_we    <= 1'b0;
         r_rsp_data  <= '0;
         r_rd_cnt    <= 8'd0;
         r_wr_cnt    <= 8'd0;
      end else begin
         r_rdy_en <= 1'b1;
         // Write enable lives for the single ISSUE cycle only.
         r_ram_we <= w_accept && req_write;
         if (w_accept) begin
            r_ram_addr  <= req_addr;
            r_ram_wdata <= req_wdata;
         end
         if (r_state == ISSUE && r_ram_we) begin
            r_wr_cnt <= r_wr_cnt + 8'd1;
            if (w_ack_wr) r_rsp_data <= r_ram_wdata;
         end
         if (r_state == CAPTURE) begin
            r_rsp_data <= ram_rdata;
            r_rd_cnt   <= r_rd_cnt + 8'd1;
         end
      end
   end

`ifdef RAM_CTRL_WRITE_ACK_EN
   logic r_rsp_is_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_is_wr <= 1'b0;
      end else if (r_state == ISSUE) begin
         r_rsp_is_wr <= r_ram_we;
      end
   end

   assign rsp_is_wr = r_rsp_is_wr;
`else
   assign rsp_is_wr = 1'b0;
`endif

   assign rsp_valid   = (r_state == RESP);
   assign busy        = (r_state != IDLE);
   assign rsp_data    = r_rsp_data;
   assign ram_addr    = r_ram_addr;
   assign ram_wdata   = r_ram_wdata;
   assign ram_we      = r_ram_we;
   assign rd_cnt      = r_rd_cnt;
   assign wr_cnt      = r_wr_cnt;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_ctrl -- self-checking bench for ram_ctrl.
// Reference model: a plain memory array, transaction counters and an
// expected-response queue; the RAM itself is a small behavioural model with
// a registered read address.
// ---------------------------------------------------------------------------
module tb_ram_ctrl;

`ifdef RAM_CTRL_WRITE_ACK_EN
   localparam bit ACK = 1'b1;
`else
   localparam bit ACK = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   logic       req_valid, req_ready, req_write;
   logic [5:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid, rsp_ready, rsp_is_wr;
   logic [7:0] rsp_data;
   logic [5:0] ram_addr;
   logic [7:0] ram_wdata, ram_rdata;
   logic       ram_we, busy;
   logic [7:0] rd_cnt, wr_cnt;
   logic [1:0] dbg_state;

   ram_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_is_wr(rsp_is_wr),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata),
      .busy(busy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
      .o_dbg_state(dbg_state)
   );

   // ---------------- RAM model (registered read address) ----------------
   logic [7:0] ram_mem [64];
   logic [5:0] ram_raddr;
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_raddr <= ram_addr;
   end
   assign ram_rdata = ram_mem[ram_raddr];

   // ---------------- reference model / scoreboard ----------------
   logic [7:0] model_mem [64];
   logic [7:0] exp_rd, exp_wr;
   logic [8:0] exp_q[$];          // {is_wr, data}
   int         n_checks = 0;
   int         n_errors = 0;
   int         reads_done = 0;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Randomise the request lines while the controller is busy; it must
   // ignore them.
   task automatic drive_noise();
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 6'($urandom_range(0, 63));
      req_wdata = 8'($urandom_range(0, 255));
   endtask

   // Called at the negedge just after the controller entered RESP.
   task automatic take_rsp(input int hold);
      logic [8:0] exp;
      exp = exp_q.pop_front();
      check_val("rsp_valid", rsp_valid, 1);
      check_val("rsp_data", rsp_data, exp[7:0]);
      check_val("rsp_is_wr", rsp_is_wr, exp[8]);
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         drive_noise();
         @(negedge clk);
         check_val("rsp_hold_valid", rsp_valid, 1);
         check_val("rsp_hold_data", rsp_data, exp[7:0]);
         check_val("rsp_hold_is_wr", rsp_is_wr, exp[8]);
         check_val("rsp_hold_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_val("rsp_done_valid", rsp_valid, 0);
      check_val("rsp_done_busy", busy, 0);
   endtask

   // One complete transaction through the controller.
   task automatic do_req(input logic wr, input logic [5:0] a,
                         input logic [7:0] d, input int hold);
      @(negedge clk);
      check_val("idle_ready", req_ready, 1);
      check_val("idle_busy", busy, 0);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(posedge clk);                       // accept edge N
      @(negedge clk);
      drive_noise();
      check_val("issue_we", ram_we, wr);
      check_val("issue_addr", ram_addr, a);
      if (wr) check_val("issue_wdata", ram_wdata, d);
      check_val("issue_busy", busy, 1);
      check_val("issue_rsp_valid", rsp_valid, 0);
      check_val("issue_ready", req_ready, 0);
      if (wr) begin
         model_mem[a] = d;
         exp_wr = exp_wr + 8'd1;
         if (ACK) exp_q.push_back({1'b1, d});
      end else begin
         exp_q.push_back({1'b0, model_mem[a]});
      end
      @(negedge clk);                       // after edge N+1
      req_valid = 1'b0;
      check_val("we_pulse", ram_we, 0);
      check_val("wr_cnt", wr_cnt, exp_wr);
      if (wr && !ACK) begin
         check_val("wr_no_rsp", rsp_valid, 0);
         check_val("wr_idle_busy", busy, 0);
      end else begin
         if (!wr) begin
            check_val("capture_rsp_valid", rsp_valid, 0);
            check_val("capture_busy", busy, 1);
            @(negedge clk);                 // after edge N+2
            exp_rd = exp_rd + 8'd1;
            reads_done++;
            check_val("rd_cnt", rd_cnt, exp_rd);
         end
         take_rsp(hold);
      end
      check_val("addr_hold", ram_addr, a);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      exp_rd = 8'd0; exp_wr = 8'd0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_we", ram_we, 0);
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_is_wr", rsp_is_wr, 0);
      check_val("rst_rsp_data", rsp_data, 0);
      check_val("rst_addr", ram_addr, 0);
      check_val("rst_wdata", ram_wdata, 0);
      check_val("rst_rd_cnt", rd_cnt, 0);
      check_val("rst_wr_cnt", wr_cnt, 0);
      check_val("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_release_ready", req_ready, 1);

      // Directed: write 5/101, read it back, then fill the RAM.
      do_req(1'b1, 6'd5, 8'd101, 0);
      check_val("first_wr_cnt", wr_cnt, 1);
      do_req(1'b0, 6'd5, 8'd0, 0);
      check_val("first_rd_cnt", rd_cnt, 1);
      for (int i = 0; i < 64; i++)
         do_req(1'b1, 6'(i), 8'($urandom_range(0, 255)), $urandom_range(0, 2));

      // Read the top address with a stalled response.
      do_req(1'b0, 6'd63, 8'd0, 5);

      // Reset during ISSUE of a write to address 7.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd7;
      req_wdata = ~model_mem[7];
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check_val("abort_we_before", ram_we, 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("abort_we", ram_we, 0);
      check_val("abort_busy", busy, 0);
      check_val("abort_rd_cnt", rd_cnt, 0);
      check_val("abort_wr_cnt", wr_cnt, 0);
      check_val("abort_rsp_valid", rsp_valid, 0);
      exp_rd = 8'd0; exp_wr = 8'd0; reads_done = 0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("abort_release_ready", req_ready, 1);

      // The aborted write must not have reached the RAM.
      do_req(1'b0, 6'd7, 8'd0, 0);

      // Random traffic until exactly 256 reads since the last reset.
      while (reads_done < 256) begin
         if ($urandom_range(0, 3) == 0)
            do_req(1'b1, 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 3));
         else
            do_req(1'b0, 6'($urandom_range(0, 63)), 8'd0, $urandom_range(0, 3));
      end
      check_val("rd_cnt_wrap", rd_cnt, 0);
      check_val("q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
